// File: rtl/udiv_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
// Holds the FSM encoding, default sizes and the divide-by-zero quotient.
package udiv_arbiter_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_DWIDTH  = 32;
    localparam int MAX_DWIDTH      = 64;

    // Sliced down to DWIDTH where it is used.
    localparam logic [MAX_DWIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/udiv_arbiter_if.sv
// Request/response bundle between the requesters and the divider arbiter.
// The master side is the set of requesters, the slave side is the arbiter.
interface udiv_arbiter_if
    import udiv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DWIDTH  = DEFAULT_DWIDTH
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DWIDTH-1:0] req_dividend;
    logic [NUM_REQ*DWIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]         rsp_quotient;
    logic [DWIDTH-1:0]         rsp_remainder;
    logic                      rsp_div_by_zero;
    logic                      busy;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder,
        input  rsp_div_by_zero, busy
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder,
        output rsp_div_by_zero, busy
    );

endinterface

// File: rtl/udiv.sv
// Sequential restoring unsigned divider, one quotient bit per enabled cycle.
// Result appears DWIDTH+1 cycles after the input handshake, as a one-cycle pulse.
module udiv #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              rst,
    input  logic              input_data_valid,
    output logic              input_ready_for_data,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic              output_data_valid,
    output logic [DWIDTH-1:0] quotient,
    output logic [DWIDTH-1:0] remainder
);

    localparam int CW = $clog2(DWIDTH + 1);

    logic              running;
    logic [CW-1:0]     count;
    logic [DWIDTH-1:0] divisor_q;
    logic [DWIDTH:0]   trial;
    logic [DWIDTH-1:0] diff;
    logic              fits;

    // quotient doubles as the dividend shift register while running
    assign trial = {remainder, quotient[DWIDTH-1]};
    assign fits  = trial >= {1'b0, divisor_q};
    assign diff  = trial[DWIDTH-1:0] - divisor_q;

    assign input_ready_for_data = !running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running           <= 1'b0;
            count             <= '0;
            divisor_q         <= '0;
            quotient          <= '0;
            remainder         <= '0;
            output_data_valid <= 1'b0;
        end else if (ce) begin
            output_data_valid <= 1'b0;
            if (!running) begin
                if (input_data_valid) begin
                    quotient  <= dividend;
                    remainder <= '0;
                    divisor_q <= divisor;
                    count     <= CW'(DWIDTH);
                    running   <= 1'b1;
                end
            end else begin
                remainder <= fits ? diff : trial[DWIDTH-1:0];
                quotient  <= {quotient[DWIDTH-2:0], fits};
                count     <= count - CW'(1);
                if (count == CW'(1)) begin
                    running           <= 1'b0;
                    output_data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/udiv_arbiter_rr_grant.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
// The caller owns and advances the pointer.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               any
);

    always_comb begin
        int j;
        logic [IDXW-1:0] jj;
        j         = 0;
        jj        = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDXW'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                grant_idx = jj;
            end
        end
    end

endmodule

// File: rtl/udiv_arbiter.sv
// Shares one sequential udiv between NUM_REQ requesters in round-robin order.
// Divide-by-zero is answered directly without touching the divider.
module udiv_arbiter
    import udiv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DWIDTH  = DEFAULT_DWIDTH
) (
    input  logic          clk,
    input  logic          rst,
    udiv_arbiter_if.slave bus
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t state, state_next;

    logic [IDXW-1:0]    ptr;
    logic [IDXW-1:0]    gnt_idx_q;
    logic [IDXW-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic               accept;
    logic [DWIDTH-1:0]  in_dividend;
    logic [DWIDTH-1:0]  in_divisor;
    logic [DWIDTH-1:0]  dividend_q;
    logic [DWIDTH-1:0]  divisor_q;
    logic               div_in_valid;
    logic               div_in_ready;
    logic               div_out_valid;
    logic [DWIDTH-1:0]  div_quotient;
    logic [DWIDTH-1:0]  div_remainder;
    logic [DWIDTH-1:0]  rsp_quotient_q;
    logic [DWIDTH-1:0]  rsp_remainder_q;
    logic               rsp_dbz_q;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_grant (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    udiv #(
        .DWIDTH (DWIDTH)
    ) u_udiv (
        .clk                  (clk),
        .ce                   (1'b1),
        .rst                  (rst),
        .input_data_valid     (div_in_valid),
        .input_ready_for_data (div_in_ready),
        .dividend             (dividend_q),
        .divisor              (divisor_q),
        .output_data_valid    (div_out_valid),
        .quotient             (div_quotient),
        .remainder            (div_remainder)
    );

    // ready is gated by rst so nothing is offered while reset is held
    assign accept = (state == ST_IDLE) && pick_any && !rst;

    always_comb begin
        in_dividend = '0;
        in_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                in_dividend = bus.req_dividend[i*DWIDTH +: DWIDTH];
                in_divisor  = bus.req_divisor[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = (in_divisor == '0) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (div_in_ready) state_next = ST_WAIT;
            ST_WAIT:  if (div_out_valid) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        div_in_valid  = 1'b0;
        case (state)
            ST_IDLE:  if (accept) bus.req_ready = pick_onehot;
            ST_ISSUE: div_in_valid = div_in_ready;
            ST_RESP:  bus.rsp_valid[gnt_idx_q] = 1'b1;
            default:  ;
        endcase
    end

    // Pointer and operands move only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr             <= '0;
            gnt_idx_q       <= '0;
            dividend_q      <= '0;
            divisor_q       <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dbz_q       <= 1'b0;
        end else begin
            if (accept) begin
                ptr        <= (pick_idx == IDXW'(NUM_REQ - 1)) ? '0 : pick_idx + IDXW'(1);
                gnt_idx_q  <= pick_idx;
                dividend_q <= in_dividend;
                divisor_q  <= in_divisor;
                if (in_divisor == '0) begin
                    rsp_quotient_q  <= DIV0_QUOTIENT[DWIDTH-1:0];
                    rsp_remainder_q <= in_dividend;
                    rsp_dbz_q       <= 1'b1;
                end
            end
            if (state == ST_WAIT && div_out_valid) begin
                rsp_quotient_q  <= div_quotient;
                rsp_remainder_q <= div_remainder;
                rsp_dbz_q       <= 1'b0;
            end
        end
    end

    assign bus.rsp_quotient    = rsp_quotient_q;
    assign bus.rsp_remainder   = rsp_remainder_q;
    assign bus.rsp_div_by_zero = rsp_dbz_q;
    assign bus.busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_udiv_arbiter.sv
// Self-checking bench for udiv_arbiter: vector table, directed corner cases
// and randomized rounds checked against a plain-arithmetic round-robin model.
module tb_udiv_arbiter;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int DIV_LAT = W + 1;
    localparam int TIMEOUT = 200;

    typedef struct {
        int           idx;
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   model_ptr = 0;
    int   issue_cnt = 0;
    bit   mon_en = 1'b0;
    int   mon_hits = 0;
    vec_t vecs[6];

    udiv_arbiter_if #(.NUM_REQ(N), .DWIDTH(W)) bus();

    udiv_arbiter #(.NUM_REQ(N), .DWIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut.div_in_valid === 1'b1) issue_cnt++;
    end

    always @(negedge clk) begin
        #2;
        if (mon_en && (bus.req_ready[1] === 1'b1 || bus.rsp_valid[1] === 1'b1)) mon_hits++;
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        bus.req_valid[idx]           = v;
        bus.req_dividend[idx*W +: W] = dvd;
        bus.req_divisor[idx*W +: W]  = dvs;
    endtask

    // Round-robin rule: first pending index at or after the requester following the last grant.
    function automatic int expGrant(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic waitGrant(input string tag, input int idx, output bit ok, output int t0);
        ok = 1'b0;
        t0 = 0;
        for (int n = 0; n < TIMEOUT && !ok; n++) begin
            @(negedge clk); #1;
            if (bus.req_ready != '0) ok = 1'b1;
        end
        if (!ok) begin
            failNow({tag, " grant"});
        end else begin
            checkOutput({tag, " grant"}, W'(bus.req_ready), W'(1 << idx));
            checkOutput({tag, " idle at grant"}, W'(bus.busy), '0);
            t0 = cyc;
            model_ptr = (idx + 1) % N;
        end
    endtask

    task automatic waitRsp(input string tag, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT && !ok; n++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != '0) ok = 1'b1;
        end
        if (!ok) failNow({tag, " response"});
    endtask

    task automatic doJob(input string tag, input int idx, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input bit edbz, input bit hold);
        bit ok;
        int t0;
        int c0;
        waitGrant(tag, idx, ok, t0);
        if (!ok) return;
        c0 = issue_cnt;
        @(posedge clk); #1;
        if (!hold) bus.req_valid[idx] = 1'b0;
        waitRsp(tag, ok);
        if (!ok) return;
        checkOutput({tag, " rsp_valid"}, W'(bus.rsp_valid), W'(1 << idx));
        checkOutput({tag, " quotient"}, bus.rsp_quotient, eq);
        checkOutput({tag, " remainder"}, bus.rsp_remainder, er);
        checkOutput({tag, " div_by_zero"}, W'(bus.rsp_div_by_zero), W'(edbz));
        checkOutput({tag, " latency"}, W'(cyc - t0), W'(edbz ? 1 : 2 + DIV_LAT));
        checkOutput({tag, " divider issues"}, W'(issue_cnt - c0), W'(edbz ? 0 : 1));
        @(posedge clk); #1;
        checkOutput({tag, " rsp_valid one cycle"}, W'(bus.rsp_valid), '0);
        checkOutput({tag, " quotient held"}, bus.rsp_quotient, eq);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        bit           ok;
        int           t0;
        int           g;
        logic [N-1:0] pend;
        logic [W-1:0] rd[N];
        logic [W-1:0] rs[N];
        logic [W-1:0] eq;
        logic [W-1:0] er;

        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b1;
        #1;
        checkOutput("reset req_ready", W'(bus.req_ready), '0);
        checkOutput("reset rsp_valid", W'(bus.rsp_valid), '0);
        checkOutput("reset quotient", bus.rsp_quotient, '0);
        checkOutput("reset remainder", bus.rsp_remainder, '0);
        checkOutput("reset div_by_zero", W'(bus.rsp_div_by_zero), '0);
        checkOutput("reset busy", W'(bus.busy), '0);
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{1, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0};
        vecs[1] = '{2, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1};
        vecs[2] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[3] = '{3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[4] = '{1, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0};
        vecs[5] = '{2, 32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].idx, 1'b1, vecs[i].dvd, vecs[i].dvs);
            doJob($sformatf("vec%0d", i), vecs[i].idx, vecs[i].q, vecs[i].r, vecs[i].dbz, 1'b0);
        end

        $display("[TB] all four requesters valid from reset");
        rst = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, W'(100 * (i + 1)), 32'd7);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        doJob("all4 r0", 0, 32'd14, 32'd2, 1'b0, 1'b0);
        doJob("all4 r1", 1, 32'd28, 32'd4, 1'b0, 1'b0);
        doJob("all4 r2", 2, 32'd42, 32'd6, 1'b0, 1'b0);
        doJob("all4 r3", 3, 32'd57, 32'd1, 1'b0, 1'b0);

        $display("[TB] fairness between requesters 0 and 3");
        applyStimulus(0, 1'b1, 32'd77, 32'd5);
        applyStimulus(3, 1'b1, 32'd90, 32'd9);
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) doJob($sformatf("fair%0d", k), 0, 32'd15, 32'd2, 1'b0, 1'b1);
            else            doJob($sformatf("fair%0d", k), 3, 32'd10, 32'd0, 1'b0, 1'b1);
        end
        bus.req_valid = '0;
        @(posedge clk); #1;

        $display("[TB] reset during WAIT");
        applyStimulus(0, 1'b1, 32'd500, 32'd3);
        waitGrant("rstwait", 0, ok, t0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
        #1;
        checkOutput("rstwait busy", W'(bus.busy), '0);
        checkOutput("rstwait rsp_valid", W'(bus.rsp_valid), '0);
        checkOutput("rstwait quotient", bus.rsp_quotient, '0);
        checkOutput("rstwait remainder", bus.rsp_remainder, '0);
        checkOutput("rstwait div_by_zero", W'(bus.rsp_div_by_zero), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != '0 || bus.busy !== 1'b0) t0++;
        end
        checkOutput("rstwait no stale response", W'(t0), '0);
        applyStimulus(0, 1'b1, 32'd500, 32'd3);
        doJob("after reset", 0, 32'd166, 32'd2, 1'b0, 1'b0);

        $display("[TB] requester 1 withdraws while busy");
        applyStimulus(0, 1'b1, 32'd9999, 32'd3);
        waitGrant("withdraw", 0, ok, t0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        mon_en = 1'b1;
        applyStimulus(1, 1'b1, 32'd50, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 32'd50, 32'd5);
        waitRsp("withdraw", ok);
        checkOutput("withdraw rsp_valid", W'(bus.rsp_valid), W'(1));
        checkOutput("withdraw quotient", bus.rsp_quotient, 32'd3333);
        repeat (40) @(posedge clk);
        #1;
        mon_en = 1'b0;
        checkOutput("withdraw no grant to 1", W'(mon_hits), '0);

        $display("[TB] randomized rounds");
        for (int round = 0; round < 8; round++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                rd[i] = $urandom;
                case ($urandom_range(0, 5))
                    0:       rs[i] = '0;
                    1, 2:    rs[i] = W'($urandom_range(1, 20));
                    default: rs[i] = $urandom >> $urandom_range(0, 31);
                endcase
                if (pend[i]) applyStimulus(i, 1'b1, rd[i], rs[i]);
            end
            while (pend != '0) begin
                g = expGrant(pend);
                if (rs[g] == '0) begin
                    eq = '1;
                    er = rd[g];
                end else begin
                    eq = rd[g] / rs[g];
                    er = rd[g] % rs[g];
                end
                doJob($sformatf("rnd%0d r%0d", round, g), g, eq, er, rs[g] == '0, 1'b0);
                pend[g] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/udiv_arbiter.md
# udiv_arbiter

Shares a single sequential `udiv` divider between `NUM_REQ` requesters, e.g. several per-channel sample CE generators that each need `sample_period_ns / CLK_PERIOD_NS` recomputed after a reset or a period change. A round-robin scheduler serialises requests through the divider and returns quotient and remainder to the granted requester. Divide-by-zero is resolved locally without occupying the divider.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 32: operand and result width.

- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_dividend`  in  NUM_REQ*DWIDTH  slice i belongs to requester i.
- `req_divisor`  in  NUM_REQ*DWIDTH  slice i belongs to requester i.
- `rsp_valid`  out  NUM_REQ  one-cycle result pulse to the owning requester.
- `rsp_quotient`  out  DWIDTH  shared result bus; valid while any `rsp_valid` bit is high.
- `rsp_remainder`  out  DWIDTH  shared result bus.
- `rsp_div_by_zero`  out  1  qualifies `rsp_valid`; set when the divisor was 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Internal `udiv` instance: `DWIDTH`, `ce=1`, `rst=rst`, operands from the latched registers.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any `req_valid` is high, the round-robin picker chooses grant g. `req_ready[g]` is asserted combinationally in that cycle, and the transfer is `req_valid[g] & req_ready[g]`. The block latches g, the dividend and the divisor.
    - Next state is RESP when the latched divisor is 0.
    - Otherwise next state is ISSUE.
  - ISSUE: drive `input_data_valid=1` only in a cycle where `input_ready_for_data=1`, then go to WAIT. Hold in ISSUE while the divider is not ready.
  - WAIT: on `output_data_valid`, register quotient and remainder and go to RESP.
  - RESP: `rsp_valid[g]=1` for exactly one cycle, then IDLE.
- Divide-by-zero result: quotient = all ones, remainder = dividend, `rsp_div_by_zero=1`.
- Round robin:
  - The priority pointer points at the requester after the last grant.
  - The search wraps from NUM_REQ-1 to 0.
  - The pointer updates only on an accepted transfer.
  - With a single requester active continuously, that requester is granted every turn.
- `req_valid` is sampled only in IDLE. A requester may drop `req_valid` before being granted with no side effects. After the handshake, the requester's inputs may change freely.
- A requester must not re-request before it receives its `rsp_valid`. If it does, the new request is queued like any other and served in turn.
- `rsp_quotient`, `rsp_remainder` and `rsp_div_by_zero` hold their last value outside RESP.

## Timing
- Reset values:
  - State IDLE, `busy=0`.
  - `req_ready=0`, `rsp_valid=0`.
  - `rsp_quotient=0`, `rsp_remainder=0`, `rsp_div_by_zero=0`.
  - Pointer set so requester 0 has highest priority.
- Reset mid-operation: the in-flight request is dropped, no `rsp_valid` is issued, and the divider is reset too.
- Handshake in cycle T:
  - Nonzero divisor: ISSUE at T+1. With divider latency L from input accept to `output_data_valid`, `rsp_valid` arrives at T+2+L when the divider is ready.
  - Zero divisor: `rsp_valid` at T+1.
- Next acceptance is possible in the cycle after RESP, i.e. T+2 for divide-by-zero. `req_ready` is never asserted while `busy`.
- Simultaneous requests: exactly one grant per IDLE cycle, lowest index at or after the pointer.

## Structure
- Shared package/header holds:
  - FSM state encodings (2 bits).
  - Divide-by-zero result constant: all ones of `DWIDTH`.
  - Default `NUM_REQ` and `DWIDTH`.
- Sub-module `rr_grant`: combinational round-robin priority picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and its index. The arbiter owns the pointer register.
- The existing `udiv` is instantiated unmodified.

## Test plan
- Single request on requester 1 (dividend 1000, divisor 10):
  - `req_ready[1]` in the same cycle.
  - `rsp_valid[1]` with quotient 100, remainder 0, `rsp_div_by_zero=0`.
- All four requesters valid from reset, with dividends 100, 200, 300, 400 and divisor 7:
  - Grants in order 0,1,2,3.
  - Results (14,2), (28,4), (42,6), (57,1).
  - Each `rsp_valid` lands only on the granted bit.
- Requester 2 with divisor 0 and dividend 55:
  - `rsp_valid[2]` one cycle after the handshake.
  - Quotient `0xFFFFFFFF`, remainder 55, `rsp_div_by_zero=1`, divider `input_data_valid` never pulses.
- Fairness: requesters 0 and 3 held valid continuously for 10 results; grants strictly alternate 0,3,0,3...
- Assert `rst` during WAIT on requester 0's job:
  - All outputs return to reset values immediately and no `rsp_valid` follows.
  - After release, a new request on requester 0 completes normally.
- Requester 1 drops `req_valid` while requester 0's job is busy: no grant or response is ever issued to requester 1.
